melody_sequencer: RTL and testbench

- Drives the 3-bit note-select input of the tone clock divider from a fixed melody table, stepping at a programmable tempo.
- Decodes 000 = low DO through 111 = high DO.
- Generates a gate that mutes the tone output between notes, plus play/pause/stop control from debounced push-buttons.
- Sits directly upstream of the divider; `gate` is ANDed with the divider's `outclk` at the audio pin.

---
 rtl/melody_sequencer.sv | 99 +++++++++
 tb/tb_melody_sequencer.sv | 114 +++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// melody_sequencer: steps a fixed melody ROM at a programmable tempo and drives note/gate to the tone divider.
module melody_sequencer #(
   parameter int BEAT_CYCLES = 12_500_000,
   parameter int GAP_CYCLES  = 1_250_000,
   parameter int LEN         = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       loop,
   output logic [2:0] note,
   output logic       gate,
   output logic [3:0] step,
   output logic       busy,
   output logic       done
);
   localparam int CW = $clog2(4 * BEAT_CYCLES);
   typedef enum logic [1:0] {IDLE, PLAY, GAP, PAUSE} state_t;
   // each entry is {note, beats}; duration is (beats+1) beats
   localparam logic [4:0] ROM [16] = '{
      5'b000_00, 5'b001_00, 5'b010_00, 5'b011_00, 5'b100_00, 5'b101_00, 5'b110_00, 5'b111_01,
      5'b111_00, 5'b110_00, 5'b101_00, 5'b100_00, 5'b011_00, 5'b010_00, 5'b001_00, 5'b000_01
   };
   state_t state, adv_state;
   logic start_q, stop_q, start_rise, stop_rise, resume_gap, adv_done, last_step;
   logic [CW-1:0] cnt, adv_cnt;
   logic [CW:0] dur, cnt_x;
   logic [3:0] adv_step;
   assign start_rise = start & ~start_q;
   assign stop_rise  = stop & ~stop_q;
   assign last_step  = step == 4'(LEN - 1);
   // one cycle of normal progress; a pausing edge also consumes its cycle so a step always totals D
   always_comb begin
      dur = (CW + 1)'((int'(ROM[step][1:0]) + 1) * BEAT_CYCLES);
      cnt_x = {1'b0, cnt};
      adv_state = state;
      adv_cnt = cnt + CW'(1);
      adv_step = step;
      adv_done = 1'b0;
      if (state == PLAY && cnt_x == dur - (CW + 1)'(GAP_CYCLES + 1))
         adv_state = GAP;
      if (state == GAP && cnt_x == dur - (CW + 1)'(1)) begin
         adv_cnt = '0;
         adv_done = last_step && !loop;
         adv_state = adv_done ? IDLE : PLAY;
         adv_step = last_step ? 4'd0 : step + 4'd1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         step <= '0;
         note <= '0;
         gate <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         resume_gap <= 1'b0;
         start_q <= 1'b1;
         stop_q <= 1'b1;
      end else begin
         start_q <= start;
         stop_q <= stop;
         done <= 1'b0;
         if (stop_rise) begin
            state <= IDLE;
            cnt <= '0;
            step <= '0;
            note <= '0;
            gate <= 1'b0;
            busy <= 1'b0;
         end else if (state == IDLE) begin
            if (start_rise) begin
               state <= PLAY;
               cnt <= '0;
               step <= '0;
               note <= ROM[0][4:2];
               gate <= 1'b1;
               busy <= 1'b1;
            end
         end else if (state == PAUSE) begin
            if (start_rise) begin
               state <= resume_gap ? GAP : PLAY;
               gate <= ~resume_gap;
            end
         end else begin
            cnt <= adv_cnt;
            step <= adv_step;
            note <= adv_done ? 3'd0 : ROM[adv_step][4:2];
            done <= adv_done;
            busy <= !adv_done;
            state <= (start_rise && !adv_done) ? PAUSE : adv_state;
            gate <= !start_rise && adv_state == PLAY;
            resume_gap <= adv_state == GAP;
         end
      end
   end
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: cycle scoreboard against a behavioural model of the melody sequencer.
module tb_melody_sequencer;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, loop = 1'b0;
   logic [2:0] note;
   logic gate, busy, done;
   logic [3:0] step;
   int passed = 0, total = 0;
   logic [9:0] sb[$];
   string tag = "reset";
   int mel[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 6, 5, 4, 3, 2, 1, 0};
   int beats[16] = '{1, 1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 1, 2};
   bit m_play, m_pause, m_done, m_sq = 1'b1, m_tq = 1'b1;
   int idx, el, lat;
   melody_sequencer #(.BEAT_CYCLES(10), .GAP_CYCLES(2), .LEN(16)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
      .note(note), .gate(gate), .step(step), .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   task automatic check(string t, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", t, got, exp);
   endtask
   // model: elapsed cycles within the note plus play/pause flags
   task automatic model_step();
      bit sr, tr;
      sr = start && !m_sq;
      tr = stop && !m_tq;
      m_done = 1'b0;
      if (reset) begin
         m_play = 1'b0; m_pause = 1'b0; idx = 0; el = 0; m_sq = 1'b1; m_tq = 1'b1;
      end else begin
         if (tr) begin
            m_play = 1'b0; m_pause = 1'b0; idx = 0; el = 0;
         end else if (!m_play) begin
            if (sr) begin m_play = 1'b1; idx = 0; el = 0; end
         end else if (m_pause) begin
            if (sr) m_pause = 1'b0;
         end else begin
            el++;
            if (el == beats[idx] * 10) begin
               el = 0;
               if (idx < 15) idx++;
               else if (loop) idx = 0;
               else begin m_play = 1'b0; idx = 0; m_done = 1'b1; end
            end
            if (sr && m_play) m_pause = 1'b1;
         end
         m_sq = start;
         m_tq = stop;
      end
   endtask
   function automatic logic [9:0] model_out();
      logic g;
      g = m_play && !m_pause && el < beats[idx] * 10 - 2;
      return {m_play ? 3'(mel[idx]) : 3'd0, g, 4'(idx), m_play, m_done};
   endfunction
   task automatic tick();
      model_step();
      sb.push_back(model_out());
      @(posedge clk);
      #1;
      check(tag, {22'd0, note, gate, step, busy, done}, {22'd0, sb.pop_front()});
   endtask
   task automatic run(int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   initial begin
      run(3);
      reset = 1'b0;
      run(2);
      tag = "play";
      start = 1'b1; tick(); start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 250; i++) begin
         tick();
         if (done === 1'b1) begin lat = i; break; end
      end
      check("done_latency", lat, 180);
      run(3);
      tag = "loop";
      loop = 1'b1; start = 1'b1; tick(); start = 1'b0;
      run(215);
      loop = 1'b0;
      run(160);
      tag = "pause";
      start = 1'b1; tick(); start = 1'b0;
      run(23);
      start = 1'b1; tick(); start = 1'b0;
      run(49);
      start = 1'b1; tick(); start = 1'b0;
      run(25);
      stop = 1'b1; tick(); stop = 1'b0; tick();
      tag = "stop_wins";
      start = 1'b1; tick(); start = 1'b0;
      run(5);
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      run(2);
      tag = "reset_gap";
      start = 1'b1; tick(); start = 1'b0;
      run(18);
      reset = 1'b1; tick(); reset = 1'b0;
      run(2);
      tag = "held";
      start = 1'b1; reset = 1'b1; tick(); reset = 1'b0;
      run(5);
      start = 1'b0; tick();
      start = 1'b1; tick(); start = 1'b0;
      run(12);
      stop = 1'b1; tick(); stop = 1'b0; tick();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
